// File: rtl/advtim_seq_ctrl.sv
// rtl/advtim_seq_ctrl.sv - config-set FIFO and sequencer feeding period/compare values to an advanced timer
module advtim_seq_ctrl #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] ARR_RST = 16'h0032
) (
  input  logic                     pe_gen_clk,
  input  logic                     pe_gen_rst,
  input  logic                     seq_start,
  input  logic                     seq_stop,
  input  logic                     seq_loop,
  input  logic                     wr_en,
  input  logic [15:0]              wr_arr,
  input  logic [15:0]              wr_cc1,
  input  logic                     pe_gen_hw_update,
  input  logic                     pe_gen_reloaded,
  input  logic                     pe_gen_tim_end,
  input  logic                     fault_detected,
  output logic                     pe_gen_tim_enable,
  output logic                     pe_gen_logic_clr,
  output logic [15:0]              r_arr,
  output logic [15:0]              r_cc1,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [1:0]               seq_state,
  output logic                     int_seq_done,
  output logic                     int_seq_fault,
  output logic                     int_seq_underrun,
  output logic                     int_seq_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   mem_arr [DEPTH];
  logic [15:0]   mem_cc1 [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          flush;
  logic          push;
  logic          overflow;
  logic [15:0]   head_arr;
  logic [15:0]   head_cc1;

  assign fifo_full  = (fifo_level == LW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign seq_state  = state;
  assign head_arr   = mem_arr[rd_ptr];
  assign head_cc1   = mem_cc1[rd_ptr];

  // Decide this cycle's FIFO pop/flush from the state and the prioritised requests
  always_comb begin
    pop   = 1'b0;
    flush = 1'b0;
    case (state)
      S_IDLE: pop = seq_start && !fault_detected && !fifo_empty;
      S_RUN: begin
        flush = fault_detected;
        pop   = !fault_detected && !seq_stop && !pe_gen_tim_end &&
                pe_gen_hw_update && !fifo_empty;
      end
      default: flush = fault_detected;
    endcase
    // A push is accepted when there is room, or when the head leaves in the same cycle
    push     = wr_en && !flush && (!fifo_full || pop);
    overflow = wr_en && !flush && fifo_full && !pop;
  end

  // FIFO storage; entries need no reset because the level gates every read
  always_ff @(posedge pe_gen_clk) begin
    if (push) begin
      mem_arr[wr_ptr] <= wr_arr;
      mem_cc1[wr_ptr] <= wr_cc1;
    end
  end

  // FIFO pointers and level; a fault flush empties the queue and drops any same-cycle push
  always_ff @(posedge pe_gen_clk or posedge pe_gen_rst) begin
    if (pe_gen_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sequencer: state, timer controls, presented values and interrupt pulses
  always_ff @(posedge pe_gen_clk or posedge pe_gen_rst) begin
    if (pe_gen_rst) begin
      state             <= S_IDLE;
      pe_gen_tim_enable <= 1'b0;
      pe_gen_logic_clr  <= 1'b0;
      r_arr             <= ARR_RST;
      r_cc1             <= 16'h0000;
      int_seq_done      <= 1'b0;
      int_seq_fault     <= 1'b0;
      int_seq_underrun  <= 1'b0;
      int_seq_overflow  <= 1'b0;
    end else begin
      pe_gen_logic_clr <= 1'b0;
      int_seq_done     <= 1'b0;
      int_seq_fault    <= 1'b0;
      int_seq_underrun <= 1'b0;
      int_seq_overflow <= overflow;
      if (pop) begin
        r_arr <= head_arr;
        r_cc1 <= head_cc1;
      end
      if (state == S_IDLE) begin
        pe_gen_tim_enable <= 1'b0;
        if (seq_start && !fault_detected) begin
          if (!fifo_empty) begin
            state            <= S_LOAD;
            pe_gen_logic_clr <= 1'b1;
          end else begin
            int_seq_underrun <= 1'b1;
          end
        end
      end else if (fault_detected) begin
        state             <= S_IDLE;
        pe_gen_tim_enable <= 1'b0;
        int_seq_fault     <= 1'b1;
      end else if (seq_stop) begin
        state             <= S_IDLE;
        pe_gen_tim_enable <= 1'b0;
        pe_gen_logic_clr  <= 1'b1;
      end else if (pe_gen_tim_end && state != S_LOAD) begin
        state             <= S_IDLE;
        pe_gen_tim_enable <= 1'b0;
        int_seq_done      <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            state             <= S_RUN;
            pe_gen_tim_enable <= 1'b1;
          end
          S_RUN: begin
            // Dry FIFO at a pre-end: keep repeating the last set, or let the period finish
            if (pe_gen_hw_update && fifo_empty && !seq_loop) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (pe_gen_reloaded) begin
              state             <= S_IDLE;
              pe_gen_tim_enable <= 1'b0;
              int_seq_done      <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_advtim_seq_ctrl.sv
// tb/tb_advtim_seq_ctrl.sv - self-checking bench for advtim_seq_ctrl
module tb_advtim_seq_ctrl;

  localparam int DEPTH = 4;
  localparam logic [15:0] ARR_RST = 16'h0032;

  logic pe_gen_clk = 1'b0;
  logic pe_gen_rst;
  logic seq_start, seq_stop, seq_loop, wr_en;
  logic [15:0] wr_arr, wr_cc1;
  logic pe_gen_hw_update, pe_gen_reloaded, pe_gen_tim_end, fault_detected;
  logic pe_gen_tim_enable, pe_gen_logic_clr;
  logic [15:0] r_arr, r_cc1;
  logic [$clog2(DEPTH):0] fifo_level;
  logic fifo_full, fifo_empty;
  logic [1:0] seq_state;
  logic int_seq_done, int_seq_fault, int_seq_underrun, int_seq_overflow;

  advtim_seq_ctrl #(.DEPTH(DEPTH), .ARR_RST(ARR_RST)) dut (
    .pe_gen_clk(pe_gen_clk), .pe_gen_rst(pe_gen_rst),
    .seq_start(seq_start), .seq_stop(seq_stop), .seq_loop(seq_loop),
    .wr_en(wr_en), .wr_arr(wr_arr), .wr_cc1(wr_cc1),
    .pe_gen_hw_update(pe_gen_hw_update), .pe_gen_reloaded(pe_gen_reloaded),
    .pe_gen_tim_end(pe_gen_tim_end), .fault_detected(fault_detected),
    .pe_gen_tim_enable(pe_gen_tim_enable), .pe_gen_logic_clr(pe_gen_logic_clr),
    .r_arr(r_arr), .r_cc1(r_cc1), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .seq_state(seq_state),
    .int_seq_done(int_seq_done), .int_seq_fault(int_seq_fault),
    .int_seq_underrun(int_seq_underrun), .int_seq_overflow(int_seq_overflow)
  );

  always #5 pe_gen_clk = ~pe_gen_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sequence phase name, queued sets and expected registered outputs
  int          m_state;
  logic [31:0] q[$];
  logic        m_en, m_clr, m_done, m_flt, m_under, m_over;
  logic [15:0] m_arr, m_cc1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; q.delete();
    m_en = 0; m_clr = 0; m_done = 0; m_flt = 0; m_under = 0; m_over = 0;
    m_arr = ARR_RST; m_cc1 = 16'h0;
  endtask

  // Apply the sequencing rules to the current inputs to predict the next cycle
  task automatic model_step();
    bit pop = 0, flush = 0, full;
    int st = m_state;
    full = (q.size() == DEPTH);
    m_clr = 0; m_done = 0; m_flt = 0; m_under = 0;
    if (m_state == 0) begin
      m_en = 0;
      if (seq_start && !fault_detected) begin
        if (q.size() > 0) begin pop = 1; st = 1; m_clr = 1; end
        else m_under = 1;
      end
    end else if (fault_detected) begin
      flush = 1; st = 0; m_en = 0; m_flt = 1;
    end else if (seq_stop) begin
      st = 0; m_en = 0; m_clr = 1;
    end else if (pe_gen_tim_end && m_state != 1) begin
      st = 0; m_en = 0; m_done = 1;
    end else if (m_state == 1) begin
      st = 2; m_en = 1;
    end else if (m_state == 2) begin
      if (pe_gen_hw_update) begin
        if (q.size() > 0) pop = 1;
        else if (!seq_loop) st = 3;
      end
    end else if (pe_gen_reloaded) begin
      st = 0; m_en = 0; m_done = 1;
    end
    m_over = wr_en && !flush && full && !pop;
    if (pop) begin m_arr = q[0][31:16]; m_cc1 = q[0][15:0]; end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (wr_en && (!full || pop)) q.push_back({wr_arr, wr_cc1});
    end
    m_state = st;
  endtask

  task automatic compare_all();
    check("seq_state", seq_state, m_state);
    check("tim_enable", pe_gen_tim_enable, m_en);
    check("logic_clr", pe_gen_logic_clr, m_clr);
    check("r_arr", r_arr, m_arr);
    check("r_cc1", r_cc1, m_cc1);
    check("fifo_level", fifo_level, q.size());
    check("fifo_full", fifo_full, q.size() == DEPTH);
    check("fifo_empty", fifo_empty, q.size() == 0);
    check("int_done", int_seq_done, m_done);
    check("int_fault", int_seq_fault, m_flt);
    check("int_underrun", int_seq_underrun, m_under);
    check("int_overflow", int_seq_overflow, m_over);
  endtask

  task automatic tick();
    model_step();
    @(posedge pe_gen_clk); #1;
    compare_all();
    wr_en = 0; seq_start = 0; seq_stop = 0;
    pe_gen_hw_update = 0; pe_gen_reloaded = 0; pe_gen_tim_end = 0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] c);
    wr_en = 1; wr_arr = a; wr_cc1 = c;
    tick();
  endtask

  logic [15:0] saved_arr;

  initial begin
    pe_gen_rst = 1; seq_start = 0; seq_stop = 0; seq_loop = 0; wr_en = 0;
    wr_arr = 0; wr_cc1 = 0; pe_gen_hw_update = 0; pe_gen_reloaded = 0;
    pe_gen_tim_end = 0; fault_detected = 0;
    model_reset();
    repeat (2) @(posedge pe_gen_clk); #1;
    compare_all();
    check("rst_arr", r_arr, 16'h0032);
    pe_gen_rst = 0;

    // Two sets, start, first pre-end swaps to the second set
    push(100, 25); push(200, 50);
    seq_start = 1; tick();
    check("start_clr", pe_gen_logic_clr, 1);
    check("start_arr", r_arr, 100);
    check("start_cc1", r_cc1, 25);
    check("start_en_low", pe_gen_tim_enable, 0);
    tick();
    check("en_after_2", pe_gen_tim_enable, 1);
    pe_gen_hw_update = 1; tick();
    check("upd_arr", r_arr, 200);
    check("upd_cc1", r_cc1, 50);
    seq_stop = 1; tick();
    check("stop_idle", seq_state, 0);

    // Non-looping single set drains and finishes on reload
    seq_loop = 0; push(300, 30);
    seq_start = 1; tick(); tick();
    pe_gen_hw_update = 1; tick();
    check("drain_state", seq_state, 3);
    check("drain_en", pe_gen_tim_enable, 1);
    pe_gen_reloaded = 1; tick();
    check("done_pulse", int_seq_done, 1);
    check("done_en", pe_gen_tim_enable, 0);
    check("done_idle", seq_state, 0);
    tick();
    check("done_one_shot", int_seq_done, 0);

    // Looping single set repeats its values
    seq_loop = 1; push(80, 40);
    seq_start = 1; tick(); tick();
    for (int i = 0; i < 5; i++) begin
      pe_gen_hw_update = 1; tick();
      check("loop_state", seq_state, 2);
      check("loop_arr", r_arr, 80);
      check("loop_nodone", int_seq_done, 0);
      tick();
    end
    seq_stop = 1; tick();

    // Overflow at DEPTH, then push alongside a pop keeps the level
    for (int i = 0; i < DEPTH; i++) push(16'(10 + i), 16'(i));
    push(999, 9);
    check("ovf_pulse", int_seq_overflow, 1);
    check("ovf_level", fifo_level, DEPTH);
    wr_en = 1; wr_arr = 500; wr_cc1 = 5; seq_start = 1; tick();
    check("pushpop_level", fifo_level, DEPTH);
    check("pushpop_noovf", int_seq_overflow, 0);
    tick();
    check("run_reached", seq_state, 2);

    // Fault beats stop and hw_update in the same cycle
    saved_arr = r_arr;
    fault_detected = 1; seq_stop = 1; pe_gen_hw_update = 1; tick();
    check("flt_idle", seq_state, 0);
    check("flt_level", fifo_level, 0);
    check("flt_pulse", int_seq_fault, 1);
    check("flt_noclr", pe_gen_logic_clr, 0);
    check("flt_arr_kept", r_arr, saved_arr);
    seq_start = 1; tick();
    check("flt_idle_nounder", int_seq_underrun, 0);
    fault_detected = 0;

    // Underrun, then reset while running
    seq_start = 1; tick();
    check("under_pulse", int_seq_underrun, 1);
    check("under_en", pe_gen_tim_enable, 0);
    push(70, 7); push(71, 8);
    seq_start = 1; tick(); tick();
    check("pre_rst_run", seq_state, 2);
    #2 pe_gen_rst = 1;
    #1 model_reset();
    compare_all();
    @(posedge pe_gen_clk); #1;
    compare_all();
    pe_gen_rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) seq_loop = 1'($urandom_range(0, 1));
      wr_en            = ($urandom % 3) == 0;
      wr_arr           = 16'($urandom);
      wr_cc1           = 16'($urandom);
      seq_start        = ($urandom % 8) == 0;
      seq_stop         = ($urandom % 40) == 0;
      pe_gen_hw_update = ($urandom % 4) == 0;
      pe_gen_reloaded  = ($urandom % 5) == 0;
      pe_gen_tim_end   = ($urandom % 30) == 0;
      fault_detected   = ($urandom % 60) == 0;
      tick();
    end
    fault_detected = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
